branch_tournament_chooser: RTL
==============================

// Module: branch_tournament_chooser
// PURPOSE
//  Consumes the local and global predictor outputs in IF and selects one per branch
//    via a PC-indexed table of 2-bit chooser counters (untagged).
//  Holds each in-flight branch's {local,global} predictions in a FIFO until it resolves in EX.
//  Trains the chosen counter only when exactly one predictor was correct.
//  Sits directly downstream of the local and global branch predictors; drives the IF next-PC mux.
// PARAMETERS
//  N_ENTRIES  128  chooser counters; power of 2; index = pc[$clog2(N_ENTRIES)+1:2]
//  Q_DEPTH    4    in-flight branch FIFO depth; power of 2, >=2
// PORTS
//  clk                    in   1   clock; all state updates on posedge
//  rst_n                  in   1   asynchronous, active-low reset
//  is_branch_if           in   1   IF-stage instruction is a branch
//  pc_if                  in   32  IF-stage PC
//  loc_predict_taken_if   in   1   local predictor direction
//  glob_predict_taken_if  in   1   global predictor direction
//  predict_taken_if       out  1   final direction = use_global_if ? glob : loc
//  use_global_if          out  1   chooser counter[pc_if idx] bit 1
//  stall_if               out  1   FIFO full; upstream must hold IF branch
//  is_branch_ex           in   1   EX-stage branch resolving this cycle (in program order)
//  pc_ex                  in   32  EX-stage branch PC
//  cmp_out_ex             in   1   actual outcome (1 = taken)
//  flush                  in   1   squash all younger, unresolved branches
//  underflow_err          out  1   sticky: EX resolve seen with FIFO empty
// BEHAVIOUR
//  Reset (async on rst_n low, immediate; released synchronously by design):
//    all counters=2'b01 (weak local); FIFO count=0, pointers=0; underflow_err=0; stall_if=0.
//  Predict: combinational, 0 latency from pc_if/loc/glob; reads the pre-update table value.
//    A same-cycle EX write to the same index is not forwarded; it is visible next cycle.
//  Push: at posedge if is_branch_if && !flush && (count<Q_DEPTH || pop).
//    Stores {loc,glob}. A push while full with no pop is dropped.
//  Pop: at posedge if is_branch_ex && count!=0. Uses the head entry for training.
//  Empty-FIFO resolve (is_branch_ex && count==0): no table write; underflow_err<=1.
//    underflow_err is sticky until reset.
//  Training (on pop): loc_ok = (loc==cmp_out_ex), glob_ok = (glob==cmp_out_ex)
//    glob_ok & !loc_ok -> counter[pc_ex idx] += 1, saturate at 2'b11
//    loc_ok & !glob_ok -> counter -= 1, saturate at 2'b00
//    otherwise         -> counter unchanged
//  flush: at posedge count<=0, wr_ptr<=rd_ptr(after pop); push suppressed.
//    A same-cycle is_branch_ex still pops and trains first (it is older).
//  Simultaneous push+pop: count unchanged; allowed when full.
//  Pointers: $clog2(Q_DEPTH) bits, wrap modulo Q_DEPTH. count: $clog2(Q_DEPTH)+1 bits.
//  stall_if = (count==Q_DEPTH), registered count only; no dependence on same-cycle pop.
//  No tag check: aliasing PCs share a counter.
// TESTING
//  1 After reset, pc_if=0x60, loc=1, glob=0
//    -> use_global_if=0, predict_taken_if=1.
//  2 Push pc 0x100 (loc=0, glob=1), resolve cmp=1: counter[0x40] 01->10; next IF 0x100 -> use_global_if=1.
//    Repeat 2x -> 11, stays 11. Aliased pc 0x300 also reads 11.
//  3 Both correct (loc=glob=cmp=1), then both wrong -> counter[idx] unchanged (01).
//  4 Push 4 branches with no resolve -> stall_if=1; 5th push dropped.
//    Then push+pop in the same cycle -> count stays 4, next pop returns entry #2.
//  5 3 entries queued, flush and is_branch_ex in the same cycle
//    -> entry #1 trains its counter; count=0; stall_if=0.
//  6 is_branch_ex with FIFO empty -> underflow_err=1 sticky, table unchanged.
//    rst_n low mid-cycle -> all outputs and state at reset values before the next edge.

Source files
------------

// File: rtl/branch_tournament_chooser.sv
// Tournament chooser: PC-indexed 2-bit counters choose local vs global direction, 0-cycle predict.
// Holds in-flight {loc,glob} until EX resolve; stall_if asserts when the in-flight queue is full.
module branch_tournament_chooser #(
  parameter int N_ENTRIES = 128,
  parameter int Q_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_branch_if,
  input  logic [31:0] pc_if,
  input  logic        loc_predict_taken_if,
  input  logic        glob_predict_taken_if,
  output logic        predict_taken_if,
  output logic        use_global_if,
  output logic        stall_if,
  input  logic        is_branch_ex,
  input  logic [31:0] pc_ex,
  input  logic        cmp_out_ex,
  input  logic        flush,
  output logic        underflow_err
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(Q_DEPTH);

  logic [1:0]       ctr   [N_ENTRIES];
  logic [1:0]       q_dat [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [1:0]       head;
  logic             push, pop, loc_ok, glob_ok;
  logic             unused_pc;

  assign idx_if    = pc_if[IDX_W+1:2];
  assign idx_ex    = pc_ex[IDX_W+1:2];
  assign unused_pc = ^{pc_if[31:IDX_W+2], pc_if[1:0], pc_ex[31:IDX_W+2], pc_ex[1:0]};

  // Table read is the pre-update value; a same-cycle EX write shows up next cycle.
  assign use_global_if    = ctr[idx_if][1];
  assign predict_taken_if = use_global_if ? glob_predict_taken_if : loc_predict_taken_if;
  assign stall_if         = (count == FULL);

  assign pop        = is_branch_ex && (count != '0);
  assign push       = is_branch_if && !flush && ((count < FULL) || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

  // head = {loc, glob} of the oldest in-flight branch
  assign head    = q_dat[rd_ptr];
  assign loc_ok  = (head[1] == cmp_out_ex);
  assign glob_ok = (head[0] == cmp_out_ex);

  always_ff @(posedge clk) begin
    if (push) q_dat[wr_ptr] <= {loc_predict_taken_if, glob_predict_taken_if};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (is_branch_ex && (count == '0)) underflow_err <= 1'b1;
      // Flush drops everything younger than the branch popping this cycle.
      if (flush) begin
        count  <= '0;
        wr_ptr <= rd_ptr_nxt;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (pop) begin
      if (glob_ok && !loc_ok && (ctr[idx_ex] != 2'b11))
        ctr[idx_ex] <= ctr[idx_ex] + 1'b1;
      else if (loc_ok && !glob_ok && (ctr[idx_ex] != 2'b00))
        ctr[idx_ex] <= ctr[idx_ex] - 1'b1;
    end
  end
endmodule
